pipe_adder: RTL and testbench

//   Parametrised pipelined ripple-carry adder, successor to the 1-bit gate-level full adder.

---
 rtl/pipe_adder.sv | 117 +++++++++++
 tb/tb_pipe_adder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit add split into STAGES carry-chained slices, optional signed overflow flag (PIPE_ADDER_OVF_EN).
// Latency: STAGES clock edges from input acceptance to registered sum/cout, one add per cycle when unstalled.
// Backpressure: out_ready low with a valid result freezes every stage; in_ready drops in the same cycle.
module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // slice width handled by each stage
    localparam int SW = WIDTH / STAGES;

    // Whole pipe moves together: it advances unless a finished result is stuck at the output.
    logic advance;
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance & rst_n;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // operand bits not yet consumed when entering stage k (slice k sits in the low SW bits)
        localparam int OW = WIDTH - k * SW;

        logic [OW-1:0]         a_i;
        logic [OW-1:0]         b_i;
        logic                  c_i;
        logic                  v_i;
        logic [SW:0]           add;
        logic [(k+1)*SW-1:0]   s_nxt;
        logic [(k+1)*SW-1:0]   s_r;
        logic                  c_r;
        logic                  v_r;

        assign add = {1'b0, a_i[SW-1:0]} + {1'b0, b_i[SW-1:0]} + {{SW{1'b0}}, c_i};

        if (k == 0) begin : g_in
            assign a_i   = a;
            assign b_i   = b;
            assign c_i   = cin;
            assign v_i   = in_valid;
            assign s_nxt = add[SW-1:0];
        end else begin : g_in
            // upper operand slices ride along from the previous stage; lower sum slices are appended below
            assign a_i   = stg[k-1].g_op.a_r;
            assign b_i   = stg[k-1].g_op.b_r;
            assign c_i   = stg[k-1].c_r;
            assign v_i   = stg[k-1].v_r;
            assign s_nxt = {add[SW-1:0], stg[k-1].s_r};
        end

        // Stage register: partial sum, slice carry and valid bit, held whenever the pipe stalls.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (advance) begin
                v_r <= v_i;
                c_r <= add[SW];
                s_r <= s_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_op
            logic [OW-SW-1:0] a_r;
            logic [OW-SW-1:0] b_r;

            // Delayed copies of the operand slices still waiting for their stage.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (advance) begin
                    a_r <= a_i[OW-1:SW];
                    b_r <= b_i[OW-1:SW];
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_r;
    assign sum       = stg[STAGES-1].s_r;
    assign cout      = stg[STAGES-1].c_r;

`ifdef PIPE_ADDER_OVF_EN
    // Signed overflow: operands agree in sign but the sum sign differs. The last stage sees both MSBs.
    logic ovf_nxt;
    logic ovf_r;
    assign ovf_nxt = (stg[STAGES-1].a_i[SW-1] == stg[STAGES-1].b_i[SW-1]) &
                     (stg[STAGES-1].add[SW-1] != stg[STAGES-1].a_i[SW-1]);

    // Overflow flag registered alongside sum so it shares the same valid/hold behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (advance) begin
            ovf_r <= ovf_nxt;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: three instances (STAGES 4, 1, 16) share stimulus.
// Checks reset, exact latency, streaming, backpressure freeze/drain, mid-stream reset and overflow flag.
module tb_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;

    logic        ir_w [3];
    logic        ov_w [3];
    logic [15:0] sm_w [3];
    logic        co_w [3];
`ifdef PIPE_ADDER_OVF_EN
    logic        of_w [3];
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int lat [3] = '{4, 1, 16};

    // vector table for latency/stream runs
    logic [15:0] v_a [4];
    logic [15:0] v_b [4];
    logic        v_c [4];
    logic [15:0] e_s [4];
    logic        e_c [4];
    logic        e_o [4];

    // backpressure vectors with hand-computed results
    localparam int NB = 6;
    logic [15:0] t_a  [NB] = '{16'h0001, 16'h1000, 16'hFFFF, 16'hABCD, 16'h8001, 16'h0F0F};
    logic [15:0] t_b  [NB] = '{16'h0002, 16'h2000, 16'hFFFF, 16'h1111, 16'h8001, 16'hF0F0};
    logic        t_c  [NB] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] t_s  [NB] = '{16'h0003, 16'h3001, 16'hFFFF, 16'hBCDE, 16'h0002, 16'h0000};
    logic        t_co [NB] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int nin;
    int nout;

    pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (ir_w[0]),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (ov_w[0]),
        .out_ready (out_ready),
        .sum       (sm_w[0]),
        .cout      (co_w[0])
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (of_w[0])
`endif
    );

    pipe_adder #(.WIDTH(16), .STAGES(1)) dut_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (ir_w[1]),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (ov_w[1]),
        .out_ready (out_ready),
        .sum       (sm_w[1]),
        .cout      (co_w[1])
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (of_w[1])
`endif
    );

    pipe_adder #(.WIDTH(16), .STAGES(16)) dut_s16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (ir_w[2]),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (ov_w[2]),
        .out_ready (out_ready),
        .sum       (sm_w[2]),
        .cout      (co_w[2])
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (of_w[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [15:0] va, input logic [15:0] vb, input logic vc,
                           input logic [15:0] es, input logic ec, input logic eo);
        v_a[i] = va;
        v_b[i] = vb;
        v_c[i] = vc;
        e_s[i] = es;
        e_c[i] = ec;
        e_o[i] = eo;
    endtask

    // Drive nb back-to-back beats from the table into empty pipes and check every DUT each cycle.
    task automatic run_vec(input string nm, input int nb);
        a         = v_a[0];
        b         = v_b[0];
        cin       = v_c[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int e = 1; e <= 16 + nb; e++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                int idx;
                idx = e - lat[d];
                if (idx >= 0 && idx < nb) begin
                    chk($sformatf("%s_d%0d_e%0d_valid", nm, d, e), ov_w[d], 1);
                    chk($sformatf("%s_d%0d_e%0d_sum", nm, d, e), sm_w[d], e_s[idx]);
                    chk($sformatf("%s_d%0d_e%0d_cout", nm, d, e), co_w[d], e_c[idx]);
`ifdef PIPE_ADDER_OVF_EN
                    chk($sformatf("%s_d%0d_e%0d_ovf", nm, d, e), of_w[d], e_o[idx]);
`endif
                end else begin
                    chk($sformatf("%s_d%0d_e%0d_valid", nm, d, e), ov_w[d], 0);
                end
            end
            if (e < nb) begin
                a   = v_a[e];
                b   = v_b[e];
                cin = v_c[e];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    // One cycle of the backpressure run on the STAGES=4 instance, scoreboarding transfers.
    task automatic step(input logic ordy);
        out_ready = ordy;
        in_valid  = (nin < NB);
        if (nin < NB) begin
            a   = t_a[nin];
            b   = t_b[nin];
            cin = t_c[nin];
        end
        #1;
        if (ov_w[0] && out_ready) begin
            if (nout < NB) begin
                chk($sformatf("bp_sum_%0d", nout), sm_w[0], t_s[nout]);
                chk($sformatf("bp_cout_%0d", nout), co_w[0], t_co[nout]);
                nout++;
            end else begin
                chk("bp_extra_result", ov_w[0], 0);
            end
        end
        if (in_valid && ir_w[0]) nin++;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 16'h5555;
        b         = 16'h1234;
        cin       = 1'b1;

        // reset held two cycles with in_valid asserted
        repeat (2) @(negedge clk);
        chk("rst_out_valid", ov_w[0], 0);
        chk("rst_sum", sm_w[0], 16'h0000);
        chk("rst_cout", co_w[0], 0);
        for (int d = 0; d < 3; d++) chk($sformatf("rst_in_ready_d%0d", d), ir_w[d], 0);
`ifdef PIPE_ADDER_OVF_EN
        chk("rst_ovf", of_w[0], 0);
`endif
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("rel_in_ready_d%0d", d), ir_w[d], 1);

        // exact latency and carry wrap
        set_vec(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_vec("lat", 1);

        // back-to-back stream
        set_vec(0, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0);
        set_vec(1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        set_vec(2, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_vec("stream", 3);

        // backpressure: fill with out_ready low, stall 5 cycles, then drain
        nin  = 0;
        nout = 0;
        for (int i = 0; i < 10 && !ov_w[0]; i++) step(1'b0);
        chk("bp_fill_valid", ov_w[0], 1);
        chk("bp_fill_count", nin, 4);
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            chk($sformatf("bp_stall%0d_in_ready", i), ir_w[0], 0);
            chk($sformatf("bp_stall%0d_valid", i), ov_w[0], 1);
            chk($sformatf("bp_stall%0d_sum", i), sm_w[0], t_s[0]);
            chk($sformatf("bp_stall%0d_cout", i), co_w[0], t_co[0]);
        end
        for (int i = 0; i < 30 && nout < NB; i++) step(1'b1);
        chk("bp_drained", nout, NB);
        chk("bp_in_count", nin, NB);
        chk("bp_nodup0", ov_w[0], 0);
        step(1'b1);
        chk("bp_nodup1", ov_w[0], 0);

        // reset with three adds in flight
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h0100;
        b         = 16'h0200;
        cin       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("midrst_in_ready", ir_w[0], 0);
                rst_n = 1'b1;
            end
            chk($sformatf("midrst_valid_%0d", i), ov_w[0], 0);
        end
        set_vec(0, 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0);
        run_vec("post_rst", 1);

        // signed overflow vectors
        set_vec(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        set_vec(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_vec("ovf", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
